// File: rtl/ccff_bitstream_loader.sv
// Host-stream driver for the fabric configuration scan chains: loads one bit per
// chain per beat, and optionally re-streams the bitstream to verify the chain tails.
module ccff_bitstream_loader #(
  parameter int NUM_CHAINS = 8,
  parameter int CHAIN_LEN  = 4096,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  start,
  input  logic                  verify,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] s_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_CHAINS-1:0] mismatch,
  output logic [CNT_W-1:0]      beat_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

  state_t state_reg;
  state_t state_next;
  logic   verify_q;
  logic   accept;
  logic   pass_start;

  assign accept     = s_valid & s_ready;
  assign pass_start = (state_reg == IDLE) & start;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (accept && beat_cnt == LAST_CNT) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready       = (state_reg == LOAD);
    config_enable = (state_reg == LOAD) || (state_reg == DRAIN);
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
  end

  // Head register and shift enable form the one-cycle pipeline between host and chains;
  // a bubble leaves the head unchanged and suppresses the shift.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      verify_q      <= 1'b0;
      ccff_head     <= '0;
      ccff_shift_en <= 1'b0;
      beat_cnt      <= '0;
    end else begin
      ccff_shift_en <= accept;
      if (accept) begin
        ccff_head <= s_data;
      end
      if (pass_start) begin
        verify_q <= verify;
        beat_cnt <= '0;
      end else if (accept && beat_cnt != FULL_CNT) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Tail bit leaving the chain during a shift is the beat loaded CHAIN_LEN shifts ago.
  generate
    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_mismatch
      always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
          mismatch[gi] <= 1'b0;
        end else if (pass_start && verify) begin
          mismatch[gi] <= 1'b0;
        end else if (verify_q && ccff_shift_en && (ccff_tail[gi] ^ ccff_head[gi])) begin
          mismatch[gi] <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a 4-deep behavioural model of
// the fabric chains feeding ccff_tail.
module tb_ccff_bitstream_loader;

  localparam int NC    = 8;
  localparam int LEN   = 4;
  localparam int CNT_W = $clog2(LEN + 1);

  logic            prog_clk = 1'b0;
  logic            prog_reset_n = 1'b0;
  logic            start = 1'b0;
  logic            verify = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [NC-1:0]   s_data = '0;
  logic [NC-1:0]   ccff_head;
  logic [NC-1:0]   ccff_tail;
  logic            ccff_shift_en;
  logic            config_enable;
  logic            busy;
  logic            done;
  logic [NC-1:0]   mismatch;
  logic [CNT_W-1:0] beat_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int pass_no  = 0;

  logic [NC-1:0] beats [LEN];
  logic [NC-1:0] chain [LEN] = '{default: '0};
  logic [NC-1:0] done_mm;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(
    .NUM_CHAINS(NC),
    .CHAIN_LEN (LEN)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .verify       (verify),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .ccff_shift_en(ccff_shift_en),
    .config_enable(config_enable),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .beat_cnt     (beat_cnt)
  );

  // Fabric model: chain[0] is next to the head, chain[LEN-1] drives the tail.
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      for (int k = LEN - 1; k > 0; k--) chain[k] <= chain[k-1];
      chain[0] <= ccff_head;
    end
  end
  assign ccff_tail = chain[LEN-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_beats(input logic [NC-1:0] b0, input logic [NC-1:0] b1,
                           input logic [NC-1:0] b2, input logic [NC-1:0] b3);
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
  endtask

  // Runs one pass from IDLE. Called at a negedge; t counts negedges from the first
  // LOAD cycle. exp_done_at is done's cycle offset from the first accept cycle.
  task automatic run_pass(input logic v, input logic [3:0] bubble_after,
                          input logic mid_start, input int exp_done_at);
    int   acc, sh, first, done_at, ndone;
    logic exp_shift, bub, prev_cfg;
    acc = 0; sh = 0; first = -1; done_at = -1; ndone = 0;
    exp_shift = 1'b0; bub = 1'b0; prev_cfg = 1'b0;
    start = 1'b1; verify = v;
    @(negedge prog_clk);
    start = 1'b0;
    for (int t = 0; t < 12; t++) begin
      check("beat_cnt", 32'(beat_cnt), acc);
      check("s_ready", 32'(s_ready), 32'(acc < LEN));
      check("shift_en", 32'(ccff_shift_en), 32'(exp_shift));
      if (ccff_shift_en && sh < LEN) begin
        check("head", 32'(ccff_head), 32'(beats[sh]));
        sh++;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_at = t - first;
          check("cfg_before_done", 32'(prev_cfg), 1);
          check("cfg_at_done", 32'(config_enable), 0);
          done_mm = mismatch;
        end
      end
      prev_cfg = config_enable;
      s_valid = 1'b0;
      start = 1'b0;
      if (acc < LEN && !bub) begin
        s_valid = 1'b1;
        s_data  = beats[acc];
      end
      bub = 1'b0;
      exp_shift = s_valid && (acc < LEN);
      if (exp_shift) begin
        if (first < 0) first = t;
        bub = bubble_after[acc];
        acc++;
      end
      if (mid_start && t == 1) begin
        start  = 1'b1;
        verify = 1'b1;
      end
      @(negedge prog_clk);
    end
    verify = 1'b0;
    check("done_count", ndone, 1);
    check("done_latency", done_at, exp_done_at);
    check("shift_count", sh, LEN);
    check("busy_after", 32'(busy), 0);
    check("beat_cnt_hold", 32'(beat_cnt), LEN);
    pass_no++;
    $display("pass %0d: verify=%0b done_at=%0d shifts=%0d mismatch=%02h",
             pass_no, v, done_at, sh, mismatch);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge prog_clk);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_shift_en", 32'(ccff_shift_en), 0);
    check("rst_head", 32'(ccff_head), 0);
    check("rst_beat_cnt", 32'(beat_cnt), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cfg", 32'(config_enable), 0);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    // Back-to-back load pass: done in the 6th cycle counting the first accept cycle
    set_beats(8'hA5, 8'h3C, 8'hFF, 8'h00);
    run_pass(1'b0, 4'b0000, 1'b0, 5);
    check("load_mismatch", 32'(mismatch), 0);

    // Bubbles after beats 1 and 3 delay done by two cycles
    run_pass(1'b0, 4'b0101, 1'b0, 7);

    // Verify identical stream
    run_pass(1'b1, 4'b0000, 1'b0, 5);
    check("verify_ok", 32'(mismatch), 8'h00);

    // Verify with a corrupted second beat: chain 0 differs
    set_beats(8'hA5, 8'h3D, 8'hFF, 8'h00);
    run_pass(1'b1, 4'b0000, 1'b0, 5);
    check("verify_bad_done", 32'(done_mm), 8'h01);
    check("verify_bad_idle", 32'(mismatch), 8'h01);
    repeat (3) @(negedge prog_clk);
    check("verify_bad_sticky", 32'(mismatch), 8'h01);

    // Reload with start+verify pulsed mid-pass: stays a load pass, mismatch untouched
    set_beats(8'hA5, 8'h3C, 8'hFF, 8'h00);
    run_pass(1'b0, 4'b0000, 1'b1, 5);
    check("midstart_mismatch", 32'(mismatch), 8'h01);

    // Correct verify pass clears the sticky flag
    run_pass(1'b1, 4'b0000, 1'b0, 5);
    check("verify_clear", 32'(mismatch), 8'h00);

    // Reset after two beats of a load pass
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_data  = beats[k];
      @(negedge prog_clk);
    end
    s_valid = 1'b0;
    check("pre_rst_shift", 32'(ccff_shift_en), 1);
    prog_reset_n = 1'b0;
    #1;
    check("midrst_shift_en", 32'(ccff_shift_en), 0);
    check("midrst_cfg", 32'(config_enable), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_beat_cnt", 32'(beat_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge prog_clk);
      check("midrst_no_done", 32'(done), 0);
    end
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    check("after_rst_busy", 32'(busy), 0);
    run_pass(1'b0, 4'b0000, 1'b0, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
